// File: rtl/regfile_rd_port_pkg.sv
// ----------------------------------------------------------------------------
// regfile_rd_port_pkg
//  Shared types and constants for the register-file read port and its
//  load scoreboard.
//  Contents:
//   XLEN_DEFAULT  default register width
//   NREG_DEFAULT  default number of architectural registers
//   REG_X0        index of the hard-wired zero register
//   reg_idx_t     5-bit register index type
//   idx_live()    1 when an index names a writable register (not x0)
// ----------------------------------------------------------------------------
package regfile_rd_port_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int NREG_DEFAULT = 32;
   localparam int IDX_W        = 5;

   typedef logic [IDX_W-1:0] reg_idx_t;

   localparam reg_idx_t REG_X0 = 5'd0;

   function automatic logic idx_live(input reg_idx_t idx);
      return (idx != REG_X0);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
//  One pending bit per architectural register, marking registers whose value
//  is still being produced by an in-flight load. Generates the decode stall.
//  Ports:
//   clk, rst      clock, asynchronous active-high reset
//   hlt           1 = freeze pending bits
//   set_en/idx    issued load destination (marks pending)
//   clr_en/idx    writeback destination (clears pending)
//   fwd_en/idx    writeback being forwarded this cycle; masks its pending bit
//   rs1, rs2      source indices presented by decode
//   stall         combinational: a source register is pending
// ----------------------------------------------------------------------------
module regfile_scoreboard
   import regfile_rd_port_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     hlt,
   input  logic     set_en,
   input  reg_idx_t set_idx,
   input  logic     clr_en,
   input  reg_idx_t clr_idx,
   input  logic     fwd_en,
   input  reg_idx_t fwd_idx,
   input  reg_idx_t rs1,
   input  reg_idx_t rs2,
   output logic     stall
);

   logic [31:0] pending_r;
   logic [31:0] pending_nxt_s;
   logic [31:0] set_mask_s;
   logic [31:0] clr_mask_s;
   logic [31:0] fwd_mask_s;
   logic [31:0] visible_s;

   // Next pending state: clear first, then set, so a new load on the same
   // register overrides the writeback of the older one. Bit 0 never sets.
   always_comb begin
      set_mask_s    = (set_en && idx_live(set_idx)) ? (32'd1 << set_idx) : 32'd0;
      clr_mask_s    = (clr_en && idx_live(clr_idx)) ? (32'd1 << clr_idx) : 32'd0;
      pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
   end

   // Pending-bit storage; frozen while halted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_r <= 32'd0;
      end else if (!hlt) begin
         pending_r <= pending_nxt_s;
      end else begin
         pending_r <= pending_r;
      end
   end

   // Stall lookup; a register whose clearing write is forwarded this cycle
   // is not treated as pending.
   always_comb begin
      fwd_mask_s = (fwd_en && idx_live(fwd_idx)) ? (32'd1 << fwd_idx) : 32'd0;
      visible_s  = pending_r & ~fwd_mask_s;
      stall      = !rst && (visible_s[rs1] || visible_s[rs2]);
   end

endmodule

// File: rtl/regfile_rd_port.sv
// ----------------------------------------------------------------------------
// regfile_rd_port
//  Architectural register file x0..x31 with one writeback write port and two
//  registered decode read ports (1-cycle latency). A load scoreboard raises
//  ID_stall when a decode source is still awaiting a load result.
//  Ports:
//   CLK, RES            clock, asynchronous active-high reset
//   HLT                 1 = freeze all state and outputs
//   WB_we/WB_rd/WB_data writeback write
//   ID_rs1/ID_rs2       read indices
//   ID_issue/ID_rd/ID_is_load  issued instruction (loads mark scoreboard)
//   ID_rs1_data/ID_rs2_data    registered read data
//   ID_stall            combinational RAW hazard on a pending load
//  Build option:
//   REGFILE_BYPASS_EN   when defined, a same-cycle writeback to a register
//                       being read is written through to the read output and
//                       the stall for that register is suppressed.
// ----------------------------------------------------------------------------
module regfile_rd_port
   import regfile_rd_port_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int NREG = NREG_DEFAULT
)
(
   input  logic            CLK,
   input  logic            RES,
   input  logic            HLT,
   input  logic            WB_we,
   input  logic [4:0]      WB_rd,
   input  logic [XLEN-1:0] WB_data,
   input  logic [4:0]      ID_rs1,
   input  logic [4:0]      ID_rs2,
   input  logic            ID_issue,
   input  logic [4:0]      ID_rd,
   input  logic            ID_is_load,
   output logic [XLEN-1:0] ID_rs1_data,
   output logic [XLEN-1:0] ID_rs2_data,
   output logic            ID_stall
);

   logic [XLEN-1:0] regs_r [NREG];
   logic [XLEN-1:0] rd1_s;
   logic [XLEN-1:0] rd2_s;
   logic            wr_s;
   logic            byp1_s;
   logic            byp2_s;
   logic            fwd_s;

   // A write only happens when not halted; x0 is never written.
   assign wr_s = WB_we && idx_live(WB_rd) && !HLT;

`ifdef REGFILE_BYPASS_EN
   assign byp1_s = wr_s && (WB_rd == ID_rs1);
   assign byp2_s = wr_s && (WB_rd == ID_rs2);
   assign fwd_s  = wr_s;
`else
   assign byp1_s = 1'b0;
   assign byp2_s = 1'b0;
   assign fwd_s  = 1'b0;
`endif

   // Register storage; entry 0 is only ever reset, so it reads as zero.
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else if (wr_s) begin
         regs_r[WB_rd] <= WB_data;
      end else begin
         regs_r[WB_rd] <= regs_r[WB_rd];
      end
   end

   // Read-data selection: zero for x0, forwarded data on bypass, else array.
   always_comb begin
      rd1_s = {XLEN{1'b0}};
      rd2_s = {XLEN{1'b0}};
      if (!idx_live(ID_rs1)) begin
         rd1_s = {XLEN{1'b0}};
      end else if (byp1_s) begin
         rd1_s = WB_data;
      end else begin
         rd1_s = regs_r[ID_rs1];
      end
      if (!idx_live(ID_rs2)) begin
         rd2_s = {XLEN{1'b0}};
      end else if (byp2_s) begin
         rd2_s = WB_data;
      end else begin
         rd2_s = regs_r[ID_rs2];
      end
   end

   // Registered read outputs; held while halted.
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         ID_rs1_data <= {XLEN{1'b0}};
         ID_rs2_data <= {XLEN{1'b0}};
      end else if (!HLT) begin
         ID_rs1_data <= rd1_s;
         ID_rs2_data <= rd2_s;
      end else begin
         ID_rs1_data <= ID_rs1_data;
         ID_rs2_data <= ID_rs2_data;
      end
   end

   regfile_scoreboard u_scoreboard (
      .clk     (CLK),
      .rst     (RES),
      .hlt     (HLT),
      .set_en  (ID_issue && ID_is_load),
      .set_idx (ID_rd),
      .clr_en  (WB_we),
      .clr_idx (WB_rd),
      .fwd_en  (fwd_s),
      .fwd_idx (WB_rd),
      .rs1     (ID_rs1),
      .rs2     (ID_rs2),
      .stall   (ID_stall)
   );

endmodule

// File: tb/tb_regfile_rd_port.sv
// ----------------------------------------------------------------------------
// tb_regfile_rd_port
//  Self-checking bench for regfile_rd_port. A table of per-cycle vectors is
//  applied; the stall is checked before the edge and the expected read data
//  is queued and compared after the edge. Hand sequences cover reset.
//  Expectations that depend on REGFILE_BYPASS_EN use the BYP constant.
// ----------------------------------------------------------------------------
module tb_regfile_rd_port;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        CLK;
   logic        RES;
   logic        HLT;
   logic        WB_we;
   logic [4:0]  WB_rd;
   logic [31:0] WB_data;
   logic [4:0]  ID_rs1;
   logic [4:0]  ID_rs2;
   logic        ID_issue;
   logic [4:0]  ID_rd;
   logic        ID_is_load;
   logic [31:0] ID_rs1_data;
   logic [31:0] ID_rs2_data;
   logic        ID_stall;

   regfile_rd_port #(.XLEN(32), .NREG(32)) dut (
      .CLK         (CLK),
      .RES         (RES),
      .HLT         (HLT),
      .WB_we       (WB_we),
      .WB_rd       (WB_rd),
      .WB_data     (WB_data),
      .ID_rs1      (ID_rs1),
      .ID_rs2      (ID_rs2),
      .ID_issue    (ID_issue),
      .ID_rd       (ID_rd),
      .ID_is_load  (ID_is_load),
      .ID_rs1_data (ID_rs1_data),
      .ID_rs2_data (ID_rs2_data),
      .ID_stall    (ID_stall)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic        hlt;
      logic        we;
      logic [4:0]  wrd;
      logic [31:0] wdata;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        iss;
      logic [4:0]  ird;
      logic        ld;
      logic        exp_stall;
      logic [31:0] exp_d1;
      logic [31:0] exp_d2;
   } vec_t;

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      int          id;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[19];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic hlt, input logic we, input logic [4:0] wrd,
                               input logic [31:0] wdata, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic iss, input logic [4:0] ird,
                               input logic ld, input logic st, input logic [31:0] d1,
                               input logic [31:0] d2);
      vec_t v;
      v.hlt = hlt; v.we = we; v.wrd = wrd; v.wdata = wdata;
      v.rs1 = rs1; v.rs2 = rs2; v.iss = iss; v.ird = ird; v.ld = ld;
      v.exp_stall = st; v.exp_d1 = d1; v.exp_d2 = d2;
      return v;
   endfunction

   task automatic chk(input string nm, input int id, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %h, expected %h", nm, id, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      HLT        = v.hlt;
      WB_we      = v.we;
      WB_rd      = v.wrd;
      WB_data    = v.wdata;
      ID_rs1     = v.rs1;
      ID_rs2     = v.rs2;
      ID_issue   = v.iss;
      ID_rd      = v.ird;
      ID_is_load = v.ld;
   endtask

   // Starts one tick after a rising edge; ends one tick after the next one.
   task automatic apply(input vec_t v, input int id);
      exp_t e;
      drive(v);
      #2;
      chk("stall", id, {31'd0, ID_stall}, {31'd0, v.exp_stall});
      exp_q.push_back('{d1: v.exp_d1, d2: v.exp_d2, id: id});
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      chk("rs1_data", e.id, ID_rs1_data, e.d1);
      chk("rs2_data", e.id, ID_rs2_data, e.d2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t idle;
      idle = mk(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);

      //           hlt   we    wrd    wdata          rs1    rs2    iss   ird    ld    stall  d1 / d2
      vecs[0]  = mk(1'b0, 1'b1, 5'd3,  32'h12345678, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 32'h0, 32'h0);
      vecs[1]  = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 32'h12345678, 32'h0);
      vecs[2]  = mk(1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd3,  1'b0, 5'd0,  1'b0, 1'b0, 32'h0, 32'h12345678);
      vecs[3]  = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 1'b0, 32'h0, 32'h0);
      vecs[4]  = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  1'b1, 5'd7,  1'b1, 1'b0, 32'h12345678, 32'h0);
      vecs[5]  = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd3,  5'd7,  1'b0, 5'd0,  1'b0, 1'b1, 32'h12345678, 32'h0);
      vecs[6]  = mk(1'b0, 1'b1, 5'd7,  32'h000000A5, 5'd3,  5'd7,  1'b0, 5'd0,  1'b0, !BYP, 32'h12345678,
                    BYP ? 32'h000000A5 : 32'h0);
      vecs[7]  = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd3,  5'd7,  1'b0, 5'd0,  1'b0, 1'b0, 32'h12345678, 32'h000000A5);
      vecs[8]  = mk(1'b0, 1'b1, 5'd9,  32'h00000099, 5'd9,  5'd0,  1'b1, 5'd9,  1'b1, 1'b0,
                    BYP ? 32'h00000099 : 32'h0, 32'h0);
      vecs[9]  = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 32'h00000099, 32'h0);
      vecs[10] = mk(1'b0, 1'b1, 5'd9,  32'h00000199, 5'd9,  5'd10, 1'b1, 5'd10, 1'b1, !BYP,
                    BYP ? 32'h00000199 : 32'h00000099, 32'h0);
      vecs[11] = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd9,  5'd10, 1'b0, 5'd0,  1'b0, 1'b1, 32'h00000199, 32'h0);
      vecs[12] = mk(1'b0, 1'b1, 5'd10, 32'h0000010A, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 32'h0, 32'h0);
      vecs[13] = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd10, 5'd10, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0000010A, 32'h0000010A);
      vecs[14] = mk(1'b1, 1'b1, 5'd4,  32'h00000055, 5'd3,  5'd4,  1'b0, 5'd0,  1'b0, 1'b0, 32'h0000010A, 32'h0000010A);
      vecs[15] = mk(1'b1, 1'b0, 5'd0,  32'h0,        5'd11, 5'd11, 1'b1, 5'd11, 1'b1, 1'b0, 32'h0000010A, 32'h0000010A);
      vecs[16] = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd4,  5'd11, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0, 32'h0);
      vecs[17] = mk(1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd3,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 32'h12345678, 32'h0);
      vecs[18] = mk(1'b0, 1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 1'b0, 5'd0,  1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);

      // Power-on reset.
      RES = 1'b1;
      drive(idle);
      #3;
      chk("reset_stall", 0, {31'd0, ID_stall}, 32'd0);
      #9;
      RES = 1'b0;
      #1;
      chk("reset_rs1", 0, ID_rs1_data, 32'd0);
      chk("reset_rs2", 0, ID_rs2_data, 32'd0);
      @(posedge CLK);
      #1;

      for (int i = 0; i < 19; i++) begin
         apply(vecs[i], i);
      end

      // Reset in the middle of operation: data and pending marks are dropped.
      apply(mk(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd31, 5'd31, 1'b0, 5'd0, 1'b0, 1'b0,
               32'hFFFFFFFF, 32'hFFFFFFFF), 100);
      apply(mk(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0,
               32'hDEADBEEF, 32'h0), 101);
      drive(mk(1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0));
      #2;
      chk("pre_reset_stall", 102, {31'd0, ID_stall}, 32'd1);
      RES = 1'b1;
      #1;
      chk("mid_reset_rs1", 102, ID_rs1_data, 32'd0);
      chk("mid_reset_rs2", 102, ID_rs2_data, 32'd0);
      chk("mid_reset_stall", 102, {31'd0, ID_stall}, 32'd0);
      @(posedge CLK);
      #2;
      RES = 1'b0;
      @(posedge CLK);
      #1;
      apply(mk(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd12, 1'b0, 5'd0, 1'b0, 1'b0,
               32'h0, 32'h0), 103);
      apply(mk(1'b0, 1'b1, 5'd5, 32'h00000005, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
               BYP ? 32'h00000005 : 32'h0, 32'h0), 104);
      apply(mk(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0,
               32'h00000005, 32'h0), 105);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
